shared_mem_arbiter: RTL and testbench

Sequences all reads on the shared flash/PSRAM bus for the cartridge.
- Arbitrates between two byte-wide requesters: PRG (CPU side) and CHR (PPU side).
- Generates flash_reset_n power-up sequencing and asynchronous flash read timing.
- Returns the selected byte of each 16-bit flash word to its requester.
- Sits between the cartridge mapper logic and the board-level shared bus pins; the tristate data pad is handled above this block.

---
 rtl/shared_mem_pkg.sv | 34 +++
 rtl/mem_rr_arb.sv | 35 +++
 rtl/shared_mem_arbiter.sv | 168 ++++++++++++++++
 tb/tb_shared_mem_arbiter.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/shared_mem_pkg.sv
// Shared types and default timing for the cartridge flash/PSRAM bus sequencer.
// Holds the FSM encoding, requester ids and the word-address helper.
package shared_mem_pkg;

  typedef enum logic [2:0] {
    RST_ASSERT = 3'd0,
    RST_WAIT   = 3'd1,
    IDLE       = 3'd2,
    READ       = 3'd3,
    GAP        = 3'd4
  } state_e;

  typedef enum logic {
    PORT_PRG = 1'b0,
    PORT_CHR = 1'b1
  } port_e;

  localparam int DEF_READ_WAIT   = 5;
  localparam int DEF_GAP_CYCLES  = 1;
  localparam int DEF_RST_LOW     = 4;
  localparam int DEF_RST_RECOVER = 10;

  localparam logic [22:0] DEF_PRG_BASE = 23'h000000;
  localparam logic [22:0] DEF_CHR_BASE = 23'h004000;

  localparam int CNT_W = 16;

  // Byte address bit 0 picks the half-word lane, so only addr[n:1] reaches the bus.
  function automatic logic [22:0] word_addr(input logic [22:0] base,
                                            input logic [13:0] word_off);
    return base + {9'd0, word_off};
  endfunction

endpackage

// File: rtl/mem_rr_arb.sv
// Two-way round-robin grant between PRG and CHR; last_grant starts at PRG
// so CHR wins the first tie after reset.
import shared_mem_pkg::*;

module mem_rr_arb (
  input  logic  clk_i,
  input  logic  rst_i,
  input  logic  req_prg_i,
  input  logic  req_chr_i,
  input  logic  take_i,
  output logic  valid_o,
  output port_e grant_o
);

  port_e last_grant_q;

  always_comb begin
    valid_o = req_prg_i | req_chr_i;
    grant_o = PORT_PRG;
    if (req_prg_i && req_chr_i) begin
      grant_o = (last_grant_q == PORT_PRG) ? PORT_CHR : PORT_PRG;
    end else if (req_chr_i) begin
      grant_o = PORT_CHR;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      last_grant_q <= PORT_PRG;
    end else if (take_i && valid_o) begin
      last_grant_q <= grant_o;
    end
  end

endmodule

// File: rtl/shared_mem_arbiter.sv
// Sequences flash reset and asynchronous reads on the shared cartridge bus,
// serving byte reads for the PRG and CHR requesters one at a time.
import shared_mem_pkg::*;

module shared_mem_arbiter #(
  parameter int          READ_WAIT   = DEF_READ_WAIT,
  parameter int          GAP_CYCLES  = DEF_GAP_CYCLES,
  parameter int          RST_LOW     = DEF_RST_LOW,
  parameter int          RST_RECOVER = DEF_RST_RECOVER,
  parameter logic [22:0] PRG_BASE    = DEF_PRG_BASE,
  parameter logic [22:0] CHR_BASE    = DEF_CHR_BASE
) (
  input  logic        clk_sys,
  input  logic        rst,
  input  logic        prg_req,
  input  logic [14:0] prg_addr,
  output logic        prg_ack,
  output logic [7:0]  prg_data,
  input  logic        chr_req,
  input  logic [13:0] chr_addr,
  output logic        chr_ack,
  output logic [7:0]  chr_data,
  input  logic [15:0] shared_d_in,
  output logic [22:0] shared_a,
  output logic        shared_oe_n,
  output logic        shared_we_n,
  output logic        flash_ce_n,
  output logic        flash_reset_n,
  output logic        psram_ce_n,
  output logic        ready
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ready_q, ready_d;
  logic [22:0]      shared_a_q, shared_a_d;
  logic             sel_hi_q, sel_hi_d;
  port_e            gnt_id_q, gnt_id_d;
  logic             prg_ack_q, prg_ack_d;
  logic             chr_ack_q, chr_ack_d;
  logic [7:0]       prg_data_q, prg_data_d;
  logic [7:0]       chr_data_q, chr_data_d;

  logic             arb_valid;
  port_e            arb_grant;
  logic             arb_take;
  logic [7:0]       rd_byte;

  mem_rr_arb u_arb (
    .clk_i     (clk_sys),
    .rst_i     (rst),
    .req_prg_i (prg_req),
    .req_chr_i (chr_req),
    .take_i    (arb_take),
    .valid_o   (arb_valid),
    .grant_o   (arb_grant)
  );

  assign rd_byte = sel_hi_q ? shared_d_in[15:8] : shared_d_in[7:0];

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q + 1'b1;
    ready_d    = ready_q;
    shared_a_d = shared_a_q;
    sel_hi_d   = sel_hi_q;
    gnt_id_d   = gnt_id_q;
    prg_ack_d  = 1'b0;
    chr_ack_d  = 1'b0;
    prg_data_d = prg_data_q;
    chr_data_d = chr_data_q;
    arb_take   = 1'b0;

    case (state_q)
      RST_ASSERT: begin
        if (cnt_q == CNT_W'(RST_LOW - 1)) begin
          state_d = RST_WAIT;
          cnt_d   = '0;
        end
      end
      RST_WAIT: begin
        if (cnt_q == CNT_W'(RST_RECOVER - 1)) begin
          state_d = IDLE;
          cnt_d   = '0;
          ready_d = 1'b1;
        end
      end
      IDLE: begin
        cnt_d = '0;
        if (arb_valid) begin
          arb_take = 1'b1;
          state_d  = READ;
          gnt_id_d = arb_grant;
          if (arb_grant == PORT_CHR) begin
            shared_a_d = word_addr(CHR_BASE, {1'b0, chr_addr[13:1]});
            sel_hi_d   = chr_addr[0];
          end else begin
            shared_a_d = word_addr(PRG_BASE, prg_addr[14:1]);
            sel_hi_d   = prg_addr[0];
          end
        end
      end
      READ: begin
        // Data is sampled on the edge that closes the final READ cycle.
        if (cnt_q == CNT_W'(READ_WAIT - 1)) begin
          state_d = GAP;
          cnt_d   = '0;
          if (gnt_id_q == PORT_CHR) begin
            chr_data_d = rd_byte;
            chr_ack_d  = 1'b1;
          end else begin
            prg_data_d = rd_byte;
            prg_ack_d  = 1'b1;
          end
        end
      end
      GAP: begin
        if (cnt_q == CNT_W'(GAP_CYCLES - 1)) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = RST_ASSERT;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (rst) begin
      state_q    <= RST_ASSERT;
      cnt_q      <= '0;
      ready_q    <= 1'b0;
      shared_a_q <= '0;
      sel_hi_q   <= 1'b0;
      gnt_id_q   <= PORT_PRG;
      prg_ack_q  <= 1'b0;
      chr_ack_q  <= 1'b0;
      prg_data_q <= 8'h00;
      chr_data_q <= 8'h00;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ready_q    <= ready_d;
      shared_a_q <= shared_a_d;
      sel_hi_q   <= sel_hi_d;
      gnt_id_q   <= gnt_id_d;
      prg_ack_q  <= prg_ack_d;
      chr_ack_q  <= chr_ack_d;
      prg_data_q <= prg_data_d;
      chr_data_q <= chr_data_d;
    end
  end

  assign flash_reset_n = (state_q != RST_ASSERT);
  assign flash_ce_n    = (state_q != READ);
  assign shared_oe_n   = (state_q != READ);
  assign shared_we_n   = 1'b1;
  assign psram_ce_n    = 1'b1;
  assign shared_a      = shared_a_q;
  assign ready         = ready_q;
  assign prg_ack       = prg_ack_q;
  assign chr_ack       = chr_ack_q;
  assign prg_data      = prg_data_q;
  assign chr_data      = chr_data_q;

endmodule

// File: tb/tb_shared_mem_arbiter.sv
// Directed bench for shared_mem_arbiter: reset sequencing, single reads,
// round-robin ties, reset during a read, and the constant bus strobes.
module tb_shared_mem_arbiter;

  localparam int READ_WAIT   = 5;
  localparam int GAP_CYCLES  = 1;
  localparam int RST_LOW     = 4;
  localparam int RST_RECOVER = 10;

  logic        clk_sys = 1'b0;
  logic        rst = 1'b1;
  logic        prg_req = 1'b0;
  logic [14:0] prg_addr = '0;
  logic        prg_ack;
  logic [7:0]  prg_data;
  logic        chr_req = 1'b0;
  logic [13:0] chr_addr = '0;
  logic        chr_ack;
  logic [7:0]  chr_data;
  logic [15:0] shared_d_in;
  logic [22:0] shared_a;
  logic        shared_oe_n, shared_we_n, flash_ce_n, flash_reset_n, psram_ce_n, ready;

  int checks = 0;
  int errors = 0;

  // clock / reset block
  always #5 clk_sys = ~clk_sys;

  shared_mem_arbiter #(
    .READ_WAIT(READ_WAIT), .GAP_CYCLES(GAP_CYCLES),
    .RST_LOW(RST_LOW), .RST_RECOVER(RST_RECOVER),
    .PRG_BASE(23'h000000), .CHR_BASE(23'h004000)
  ) dut (
    .clk_sys(clk_sys), .rst(rst),
    .prg_req(prg_req), .prg_addr(prg_addr), .prg_ack(prg_ack), .prg_data(prg_data),
    .chr_req(chr_req), .chr_addr(chr_addr), .chr_ack(chr_ack), .chr_data(chr_data),
    .shared_d_in(shared_d_in), .shared_a(shared_a), .shared_oe_n(shared_oe_n),
    .shared_we_n(shared_we_n), .flash_ce_n(flash_ce_n), .flash_reset_n(flash_reset_n),
    .psram_ce_n(psram_ce_n), .ready(ready)
  );

  // Flash contents: two fixed words, everything else a simple address pattern.
  function automatic logic [15:0] flash_word(input logic [22:0] a);
    case (a)
      23'h000001: return 16'hBEEF;
      23'h004000: return 16'h1234;
      default:    return {a[7:0] ^ 8'hC3, a[15:8] ^ a[7:0]};
    endcase
  endfunction

  assign shared_d_in = flash_word(shared_a);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk_sys) begin
    check("we_n_const", 32'(shared_we_n), 32'd1);
    check("psram_ce_const", 32'(psram_ce_n), 32'd1);
    check("dual_ack", 32'(prg_ack & chr_ack), 32'd0);
  end

  // Expects rst already high; checks reset values, releases rst and times the sequence.
  task automatic reset_seq();
    int n;
    @(negedge clk_sys);
    check("rst_flash_reset_n", 32'(flash_reset_n), 32'd0);
    check("rst_ce_n", 32'(flash_ce_n), 32'd1);
    check("rst_oe_n", 32'(shared_oe_n), 32'd1);
    check("rst_shared_a", 32'(shared_a), 32'd0);
    check("rst_ready", 32'(ready), 32'd0);
    check("rst_acks", 32'({prg_ack, chr_ack}), 32'd0);
    check("rst_prg_data", 32'(prg_data), 32'd0);
    check("rst_chr_data", 32'(chr_data), 32'd0);
    rst = 1'b0;
    n = 0;
    while (flash_reset_n == 1'b0 && n < 50) begin
      @(negedge clk_sys);
      n++;
      check("pre_ready_ce_n", 32'(flash_ce_n), 32'd1);
    end
    check("rst_low_len", 32'(n), 32'(RST_LOW));
    check("ready_early", 32'(ready), 32'd0);
    n = 0;
    while (ready == 1'b0 && n < 100) begin
      @(negedge clk_sys);
      n++;
      check("pre_ready_ce_n", 32'(flash_ce_n), 32'd1);
    end
    check("recover_len", 32'(n), 32'(RST_RECOVER));
  endtask

  // Called at a negedge in IDLE; runs one read and leaves the DUT back in IDLE.
  task automatic run_read(input string tag, input bit use_chr, input logic [14:0] addr,
                          input logic [22:0] exp_a, input logic [7:0] exp_b,
                          input bit scramble, input bit glitch_prg);
    int lat, low;
    bit got;
    if (use_chr) begin chr_addr = addr[13:0]; chr_req = 1'b1; end
    else begin prg_addr = addr; prg_req = 1'b1; end
    lat = 0; low = 0; got = 1'b0;
    while (!got && lat < 30) begin
      @(negedge clk_sys);
      lat++;
      if (!flash_ce_n) begin
        low++;
        check({tag, "_addr"}, 32'(shared_a), 32'(exp_a));
        check({tag, "_oe_n"}, 32'(shared_oe_n), 32'd0);
        if (scramble && low == 1) begin
          prg_addr = ~prg_addr;
          chr_addr = ~chr_addr;
        end
        if (glitch_prg) prg_req = (low == 1);
      end
      if (prg_ack || chr_ack) got = 1'b1;
    end
    check({tag, "_ack_seen"}, 32'(got), 32'd1);
    check({tag, "_latency"}, 32'(lat), 32'(1 + READ_WAIT));
    check({tag, "_low_cycles"}, 32'(low), 32'(READ_WAIT));
    check({tag, "_ack_port"}, 32'({chr_ack, prg_ack}), use_chr ? 32'd2 : 32'd1);
    check({tag, "_data"}, use_chr ? 32'(chr_data) : 32'(prg_data), 32'(exp_b));
    prg_req = 1'b0;
    chr_req = 1'b0;
    @(negedge clk_sys);
  endtask

  initial begin
    int n, t, last_t;
    bit exp_chr [4];

    // Power-up with a PRG request already pending; nothing may start before ready.
    prg_addr = 15'h0003;
    prg_req  = 1'b1;
    reset_seq();

    run_read("prg_beef", 1'b0, 15'h0003, 23'h000001, 8'hBE, 1'b0, 1'b0);
    run_read("chr_1234", 1'b1, 15'h0000, 23'h004000, 8'h34, 1'b0, 1'b0);
    check("prg_data_hold", 32'(prg_data), 32'h0BE);
    run_read("prg_top", 1'b0, 15'h7FFE, 23'h003FFF, 8'hC0, 1'b1, 1'b0);
    run_read("chr_top", 1'b1, 15'h3FFF, 23'h005FFF, 8'h3C, 1'b0, 1'b1);
    check("chr_data_hold", 32'(chr_data), 32'h03C);

    // The PRG pulse during the CHR read was dropped before any grant.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk_sys);
      check("glitch_no_access", 32'(flash_ce_n), 32'd1);
      check("glitch_no_ack", 32'({prg_ack, chr_ack}), 32'd0);
    end

    // Reset on the third READ cycle aborts without an ack.
    prg_addr = 15'h0003;
    prg_req  = 1'b1;
    n = 0; t = 0;
    while (n < 3 && t < 20) begin
      @(negedge clk_sys);
      t++;
      if (!flash_ce_n) n++;
    end
    check("abort_reached_read", 32'(n), 32'd3);
    rst = 1'b1;
    @(negedge clk_sys);
    check("abort_ce_n", 32'(flash_ce_n), 32'd1);
    check("abort_oe_n", 32'(shared_oe_n), 32'd1);
    check("abort_flash_reset_n", 32'(flash_reset_n), 32'd0);
    check("abort_no_ack", 32'(prg_ack), 32'd0);
    check("abort_ready", 32'(ready), 32'd0);
    prg_req = 1'b0;
    reset_seq();

    // Both requesters held: CHR wins the first tie, then strict alternation.
    exp_chr = '{1'b1, 1'b0, 1'b1, 1'b0};
    prg_addr = 15'h0003;
    chr_addr = 14'h0000;
    prg_req  = 1'b1;
    chr_req  = 1'b1;
    n = 0; t = 0; last_t = 0;
    while (n < 4 && t < 80) begin
      @(negedge clk_sys);
      t++;
      if (prg_ack || chr_ack) begin
        check("rr_order", 32'({chr_ack, prg_ack}), exp_chr[n] ? 32'd2 : 32'd1);
        if (n == 0) check("rr_first_latency", 32'(t), 32'(1 + READ_WAIT));
        else        check("rr_period", 32'(t - last_t), 32'(1 + READ_WAIT + GAP_CYCLES));
        check("rr_data", exp_chr[n] ? 32'(chr_data) : 32'(prg_data),
              exp_chr[n] ? 32'h34 : 32'hBE);
        last_t = t;
        n++;
      end
    end
    check("rr_count", 32'(n), 32'd4);
    prg_req = 1'b0;
    chr_req = 1'b0;
    repeat (10) @(negedge clk_sys);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
